// File: rtl/genetic_pkg.sv
// Shared types and constants for the genetic-engine parent-pair scheduler.
// Latency: n/a (package only).
// Backpressure: n/a.
package genetic_pkg;
  localparam int IDX_W  = 5;
  localparam int LFSR_W = 32;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [1:0] {IDLE, DRAW, CHECK, GRANT} sched_state_t;

  // Galois right-shift step; shared by the LFSR and the candidate slicer.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
    return (cur >> 1) ^ (cur[0] ? LFSR_TAPS : '0);
  endfunction
endpackage

// File: rtl/lfsr32.sv
// 32-bit Galois LFSR with seed load; a zero load value maps back to SEED.
// Latency: 1 cycle from step/load to q.
// Backpressure: none; load has priority over step.
module lfsr32 import genetic_pkg::*; #(
  parameter logic [LFSR_W-1:0] SEED = 32'hACE1_2468
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              step,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  output logic [LFSR_W-1:0] q
);
  logic [LFSR_W-1:0] r_q;

  // Seed on reset or load, otherwise advance one step when asked.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= SEED;
    end else if (load) begin
      r_q <= (load_val == '0) ? SEED : load_val;
    end else if (step) begin
      r_q <= lfsr_next(r_q);
    end
  end

  assign q = r_q;
endmodule

// File: rtl/parent_pair_sched.sv
// Rejection-samples distinct in-range parent index pairs and grants them round-robin.
// Latency: 3 cycles from req to grant, +2 per rejected draw, fallback (0,1) after MAX_RETRY.
// Backpressure: requester holds req until its grant; dropping req mid-draw aborts silently.
module parent_pair_sched import genetic_pkg::*; #(
  parameter int                POP_SIZE  = 30,
  parameter int                NUM_REQ   = 2,
  parameter int                MAX_RETRY = 15,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 32'hACE1_2468
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               reseed_en,
  input  logic [LFSR_W-1:0]  reseed_val,
  output logic [NUM_REQ-1:0] grant,
  output logic               pair_valid,
  output logic [IDX_W-1:0]   idx0,
  output logic [IDX_W-1:0]   idx1,
  output logic               busy,
  output logic               fail_sticky
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  sched_state_t       r_state;
  logic [PW-1:0]      r_ptr;
  logic [PW-1:0]      r_winner;
  logic [RW-1:0]      r_retry;
  logic [IDX_W-1:0]   r_cand0;
  logic [IDX_W-1:0]   r_cand1;
  logic [NUM_REQ-1:0] r_grant;
  logic               r_pair_valid;
  logic [IDX_W-1:0]   r_idx0;
  logic [IDX_W-1:0]   r_idx1;
  logic               r_busy;
  logic               r_fail;

  logic [LFSR_W-1:0]  w_lfsr_q;
  logic [LFSR_W-1:0]  w_lfsr_next;
  logic               w_unused_bits;
  logic               w_step;
  logic [PW-1:0]      w_scan;
  logic [PW-1:0]      w_win;
  logic               w_found;
  logic [NUM_REQ-1:0] w_win_oh;
  logic               w_accept;
  logic [PW-1:0]      w_ptr_next;

  // The LFSR advances only while drawing; a reseed overrides the step.
  assign w_step = (r_state == DRAW);

  lfsr32 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .step     (w_step),
    .load     (reseed_en),
    .load_val (reseed_val),
    .q        (w_lfsr_q)
  );

  // Candidates are sliced from the value the LFSR steps to this DRAW cycle.
  assign w_lfsr_next   = lfsr_next(w_lfsr_q);
  assign w_unused_bits = ^w_lfsr_next[LFSR_W-1:2*IDX_W];

  // Round-robin search from the pointer; first asserted req wins.
  always_comb begin
    w_win   = r_ptr;
    w_found = 1'b0;
    w_scan  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_scan = PW'((int'(r_ptr) + i) % NUM_REQ);
      if (!w_found && req[w_scan]) begin
        w_found = 1'b1;
        w_win   = w_scan;
      end
    end
  end

  // One-hot grant vector for the latched winner.
  always_comb begin
    w_win_oh           = '0;
    w_win_oh[r_winner] = 1'b1;
  end

  assign w_accept   = (int'(r_cand0) < POP_SIZE) && (int'(r_cand1) < POP_SIZE) &&
                      (r_cand0 != r_cand1);
  assign w_ptr_next = (int'(r_winner) == NUM_REQ - 1) ? '0 : r_winner + 1'b1;

  // Scheduler FSM with registered grant/pair outputs; reseed aborts any draw.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_ptr        <= '0;
      r_winner     <= '0;
      r_retry      <= '0;
      r_cand0      <= '0;
      r_cand1      <= '0;
      r_grant      <= '0;
      r_pair_valid <= 1'b0;
      r_idx0       <= '0;
      r_idx1       <= '0;
      r_busy       <= 1'b0;
      r_fail       <= 1'b0;
    end else if (reseed_en) begin
      r_state      <= IDLE;
      r_retry      <= '0;
      r_grant      <= '0;
      r_pair_valid <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_grant      <= '0;
      r_pair_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_winner <= w_win;
            r_retry  <= '0;
            r_state  <= DRAW;
            r_busy   <= 1'b1;
          end
        end
        DRAW: begin
          if (!req[r_winner]) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cand0 <= w_lfsr_next[IDX_W-1:0];
            r_cand1 <= w_lfsr_next[2*IDX_W-1:IDX_W];
            r_state <= CHECK;
          end
        end
        CHECK: begin
          if (!req[r_winner]) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (w_accept) begin
            r_idx0       <= r_cand0;
            r_idx1       <= r_cand1;
            r_grant      <= w_win_oh;
            r_pair_valid <= 1'b1;
            r_state      <= GRANT;
          end else if (r_retry < RETRY_MAX) begin
            r_retry <= r_retry + 1'b1;
            r_state <= DRAW;
          end else begin
            r_idx0       <= IDX_W'(0);
            r_idx1       <= IDX_W'(1);
            r_fail       <= 1'b1;
            r_grant      <= w_win_oh;
            r_pair_valid <= 1'b1;
            r_state      <= GRANT;
          end
        end
        GRANT: begin
          r_ptr   <= w_ptr_next;
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign grant       = r_grant;
  assign pair_valid  = r_pair_valid;
  assign idx0        = r_idx0;
  assign idx1        = r_idx1;
  assign busy        = r_busy;
  assign fail_sticky = r_fail;
endmodule

// File: tb/tb_parent_pair_sched.sv
// Self-checking bench for parent_pair_sched: vector table, abort sequences, fallback, round-robin.
// Latency: checks 3-cycle minimum and +2 per rejection.
// Backpressure: requesters drop req on seeing their grant.
module tb_parent_pair_sched;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req, req_fb;
  logic        reseed_en, reseed_en_fb;
  logic [31:0] reseed_val, reseed_val_fb;
  logic [1:0]  grant, grant_fb;
  logic        pair_valid, pair_valid_fb;
  logic [4:0]  idx0, idx1, idx0_fb, idx1_fb;
  logic        busy, busy_fb;
  logic        fail_sticky, fail_sticky_fb;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  parent_pair_sched dut (
    .clk(clk), .rst_n(rst_n), .req(req), .reseed_en(reseed_en), .reseed_val(reseed_val),
    .grant(grant), .pair_valid(pair_valid), .idx0(idx0), .idx1(idx1),
    .busy(busy), .fail_sticky(fail_sticky)
  );

  parent_pair_sched #(.POP_SIZE(2), .NUM_REQ(2), .MAX_RETRY(0)) dut_fb (
    .clk(clk), .rst_n(rst_n), .req(req_fb), .reseed_en(reseed_en_fb), .reseed_val(reseed_val_fb),
    .grant(grant_fb), .pair_valid(pair_valid_fb), .idx0(idx0_fb), .idx1(idx1_fb),
    .busy(busy_fb), .fail_sticky(fail_sticky_fb)
  );

  typedef struct {
    logic [31:0] seed;
    logic [1:0]  rq;
    logic [1:0]  g;
    logic [4:0]  i0;
    logic [4:0]  i1;
    int          lat;
  } vec_t;

  typedef struct {
    logic [1:0] g;
    logic [4:0] i0;
    logic [4:0] i1;
    int         lat;   // -1: latency not checked
    logic       fs;
  } exp_t;

  vec_t vecs[6];
  exp_t sb[$];

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mnext(input logic [31:0] l);
    return (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  task automatic reseed(input bit fb, input logic [31:0] s);
    @(negedge clk);
    if (fb) begin reseed_en_fb = 1'b1; reseed_val_fb = s; end
    else    begin reseed_en    = 1'b1; reseed_val    = s; end
    @(negedge clk);
    reseed_en    = 1'b0;
    reseed_en_fb = 1'b0;
  endtask

  // Wait (bounded) for pair_valid, then pop the scoreboard and compare.
  task automatic serve(input bit fb, input string nm);
    int   lat;
    bit   ok;
    exp_t e;
    lat = 0;
    ok  = 1'b0;
    for (int c = 0; c < 60 && !ok; c++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (fb ? pair_valid_fb : pair_valid) ok = 1'b1;
    end
    e = sb.pop_front();
    if (!ok) begin
      check({nm, "_timeout"}, 0, 1);
    end else begin
      check({nm, "_grant"}, fb ? grant_fb : grant, e.g);
      check({nm, "_idx0"},  fb ? idx0_fb  : idx0,  e.i0);
      check({nm, "_idx1"},  fb ? idx1_fb  : idx1,  e.i1);
      check({nm, "_fail"},  fb ? fail_sticky_fb : fail_sticky, e.fs);
      if (e.lat >= 0) check({nm, "_lat"}, lat, e.lat);
    end
  endtask

  initial begin
    logic [31:0] ml;
    logic [4:0]  c0, c1;
    exp_t        e;

    vecs[0] = '{32'h0000_0002, 2'b01, 2'b01, 5'd1,  5'd0,  3};
    vecs[1] = '{32'h0000_0040, 2'b10, 2'b10, 5'd0,  5'd1,  3};
    vecs[2] = '{32'h0000_0042, 2'b01, 2'b01, 5'd19, 5'd0,  5};
    vecs[3] = '{32'h0000_0000, 2'b10, 2'b10, 5'd20, 5'd17, 3};
    vecs[4] = '{32'h0000_0043, 2'b01, 2'b01, 5'd2,  5'd1,  3};
    vecs[5] = '{32'h0000_07C0, 2'b10, 2'b10, 5'd16, 5'd15, 5};

    rst_n = 1'b0; req = '0; req_fb = '0;
    reseed_en = 1'b0; reseed_en_fb = 1'b0; reseed_val = '0; reseed_val_fb = '0;
    repeat (3) @(negedge clk);
    check("rst_grant", grant, 0);
    check("rst_pv", pair_valid, 0);
    check("rst_idx0", idx0, 0);
    check("rst_idx1", idx1, 0);
    check("rst_busy", busy, 0);
    check("rst_fail", fail_sticky, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven single-request cases.
    for (int i = 0; i < 6; i++) begin
      reseed(1'b0, vecs[i].seed);
      sb.push_back('{vecs[i].g, vecs[i].i0, vecs[i].i1, vecs[i].lat, 1'b0});
      req = vecs[i].rq;
      serve(1'b0, $sformatf("vec%0d", i));
      req = '0;
      @(negedge clk);
      check($sformatf("vec%0d_onecycle", i), pair_valid, 0);
      @(negedge clk);
    end

    // Reseed while in CHECK: abort, then the held req is served from the new seed.
    reseed(1'b0, 32'h2);
    req = 2'b01;
    @(negedge clk);
    @(negedge clk);
    check("chk_busy", busy, 1);
    reseed_en = 1'b1; reseed_val = 32'h2;
    @(negedge clk);
    reseed_en = 1'b0;
    check("rs_busy_drop", busy, 0);
    check("rs_no_grant", pair_valid, 0);
    sb.push_back('{2'b01, 5'd1, 5'd0, 3, 1'b0});
    serve(1'b0, "rs_reserve");
    req = '0;
    repeat (2) @(negedge clk);

    // Winner (req[1], pointer=1) drops req in DRAW; pointer must stay at 1.
    req = 2'b11;
    @(negedge clk);
    check("drop_busy", busy, 1);
    req = 2'b01;
    @(negedge clk);
    check("drop_idle", busy, 0);
    check("drop_no_grant", pair_valid, 0);
    req = 2'b11;
    begin
      int  lat;
      bit  ok;
      lat = 0; ok = 1'b0;
      for (int c = 0; c < 60 && !ok; c++) begin
        @(posedge clk); lat++; @(negedge clk);
        if (pair_valid) ok = 1'b1;
      end
      check("drop_ptr_seen", ok, 1);
      check("drop_ptr_grant", grant, 2'b10);
    end
    req = '0;
    repeat (2) @(negedge clk);

    // Reset asserted in DRAW.
    req = 2'b01;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rstdraw_busy", busy, 0);
    check("rstdraw_pv", pair_valid, 0);
    check("rstdraw_grant", grant, 0);
    check("rstdraw_idx0", idx0, 0);
    check("rstdraw_idx1", idx1, 0);
    rst_n = 1'b1; req = '0;
    repeat (2) @(negedge clk);

    // Fallback on the POP_SIZE=2 / MAX_RETRY=0 instance.
    reseed(1'b1, 32'h42);
    sb.push_back('{2'b01, 5'd0, 5'd1, 3, 1'b1});
    req_fb = 2'b01;
    serve(1'b1, "fb");
    req_fb = '0;
    repeat (3) @(negedge clk);
    check("fb_sticky_hold", fail_sticky_fb, 1);
    check("fb_idle_pv", pair_valid_fb, 0);
    reseed(1'b1, 32'h2);
    sb.push_back('{2'b10, 5'd1, 5'd0, 3, 1'b1});
    req_fb = 2'b10;
    serve(1'b1, "fb_accept");
    req_fb = '0;
    @(negedge clk);

    // Round-robin: both requests held from reset; model draws from the reset seed.
    req = 2'b11;
    rst_n = 1'b0;
    @(negedge clk);
    check("fb_sticky_clear", fail_sticky_fb, 0);
    ml = 32'hACE1_2468;
    for (int k = 0; k < 4; k++) begin
      e.g  = (k % 2 == 0) ? 2'b01 : 2'b10;
      e.lat = -1;
      e.fs = 1'b0;
      for (int r = 0; r <= 15; r++) begin
        ml = mnext(ml);
        c0 = ml[4:0];
        c1 = ml[9:5];
        if (c0 < 5'd30 && c1 < 5'd30 && c0 != c1) begin
          e.i0 = c0; e.i1 = c1;
          break;
        end
        if (r == 15) begin e.i0 = 5'd0; e.i1 = 5'd1; e.fs = 1'b1; end
      end
      sb.push_back(e);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      serve(1'b0, $sformatf("rr%0d", k));
      check($sformatf("rr%0d_legal", k),
            int'(idx0 < 5'd30 && idx1 < 5'd30 && idx0 != idx1), 1);
    end
    req = '0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
